riscv_muldiv: RTL and testbench

RISCV_MULDIV -- requirements
Module: riscv_muldiv

---
 rtl/riscv_muldiv.sv | 167 ++++++++++++++++
 tb/tb_riscv_muldiv.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv.sv
// RV32M multiply/divide unit: radix-2 iterative shift-add multiplier and
// restoring divider sharing one 2*DATA_W accumulator, one bit per cycle.
module riscv_muldiv #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic              kill,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  result_q, result_d;

    logic               rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [DATA_W-1:0]  rs1_mag, rs2_mag, special_res;
    logic [DATA_W:0]    mul_sum, div_diff;
    logic [ACC_W-1:0]   step, prod;
    logic [DATA_W-1:0]  quot_s, rem_s, final_res;

    // Operand decode at acceptance: signs, magnitudes and the early-exit divide cases
    always_comb begin
        rs1_neg  = 1'b0;
        rs2_neg  = 1'b0;
        if (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM)
            rs1_neg = rs1_data[DATA_W-1];
        if (op == OP_MULH || op == OP_DIV || op == OP_REM)
            rs2_neg = rs2_data[DATA_W-1];
        rs1_mag  = rs1_neg ? -rs1_data : rs1_data;
        rs2_mag  = rs2_neg ? -rs2_data : rs2_data;
        div_zero = op[2] && (rs2_data == '0);
        div_ovf  = (op == OP_DIV || op == OP_REM)
                   && (rs1_data == {1'b1, {(DATA_W-1){1'b0}}}) && (rs2_data == '1);
        if (div_zero)
            special_res = op[1] ? rs1_data : '1;
        else
            special_res = op[1] ? '0 : rs1_data;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]} + {1'b0, (acc_q[0] ? b_q : DATA_W'(0))};
        div_diff = {acc_q[ACC_W-1:DATA_W], acc_q[DATA_W-1]} - {1'b0, b_q};
        if (op_q[2])
            step = div_diff[DATA_W] ? {acc_q[ACC_W-2:0], 1'b0}
                                    : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        else
            step = {mul_sum, acc_q[DATA_W-1:1]};
    end

    // Sign correction and result select, applied to the final step's accumulator
    always_comb begin
        prod   = (sign1_q ^ sign2_q) ? -step : step;
        quot_s = (sign1_q ^ sign2_q) ? -step[DATA_W-1:0] : step[DATA_W-1:0];
        rem_s  = sign1_q ? -step[ACC_W-1:DATA_W] : step[ACC_W-1:DATA_W];
        case (op_q)
            OP_MUL:                      final_res = prod[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[ACC_W-1:DATA_W];
            OP_DIV, OP_DIVU:             final_res = quot_s;
            default:                     final_res = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        result_d = result_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_d    = op;
                        sign1_d = rs1_neg;
                        sign2_d = rs2_neg;
                        b_d     = rs2_mag;
                        acc_d   = {DATA_W'(0), rs1_mag};
                        cnt_d   = '0;
                        if (div_zero || div_ovf) begin
                            state_d  = DONE;
                            result_d = special_res;
                            valid_d  = 1'b1;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = step;
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                        valid_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (DATA_W=32): directed vector table,
// random ops against an arithmetic reference model, and kill/reset/throughput sequences.
module tb_riscv_muldiv;

    logic        clk = 1'b0;
    logic        reset, start, kill;
    logic [2:0]  op;
    logic [31:0] rs1_data, rs2_data;
    logic        busy, valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = 32'h0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    riscv_muldiv #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .kill(kill),
        .busy(busy), .valid(valid), .result(result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub = longint'({32'h0, b});
        longint unsigned pu;
        longint          p;
        int              ia = $signed(a);
        int              ib = $signed(b);
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op from IDLE and check result, latency, busy span and hold afterwards
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        int busy_cnt = 0;
        logic got = 1'b0;
        start = 1'b1; op = f; rs1_data = a; rs2_data = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cnt++;
            if (valid) begin
                lat = c;
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, "_got_valid"}, 32'(got), 32'd1);
        check({name, "_result"}, result, exp);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        @(posedge clk); #1;
        check({name, "_idle_after"}, {30'h0, busy, valid}, 32'h0);
        check({name, "_held"}, result, exp);
        last_res = exp;
    endtask

    initial begin
        int cyc, nv, vcount, bcount;
        int vt[2];
        logic [31:0] vr[2];
        logic pend;
        logic [2:0] f;
        logic [31:0] a, b;

        reset = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        vecs[0]  = '{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{"mulh_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{"mulhu_ones",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{"mulhsu_ones",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{"divu_by_zero",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{"rem_by_zero",   3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{"div_overflow",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{"rem_overflow",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Random ops, biased towards the divide corner cases
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, f), f, a, b, ref_model(f, a, b),
                   (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                   ? 1 : 33);
        end

        // Kill during CALC: no valid, result keeps the previous value
        start = 1'b1; op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'h0);
        vcount = 0;
        repeat (40) begin
            if (valid) vcount++;
            @(posedge clk); #1;
        end
        check("kill_no_valid", 32'(vcount), 32'h0);
        check("kill_result_held", result, last_res);

        // Start pulsed while busy is ignored
        start = 1'b1; op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 6;
        while (!valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ignore_start_latency", 32'(cyc), 32'd33);
        check("ignore_start_result", result, 32'd14);
        vcount = 0;
        bcount = 0;
        @(posedge clk); #1;
        repeat (40) begin
            if (valid) vcount++;
            if (busy) bcount++;
            @(posedge clk); #1;
        end
        check("ignore_start_no_second_op", 32'(vcount + bcount), 32'h0);

        // Reset during CALC clears everything and no valid follows
        start = 1'b1; op = 3'd1; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_valid", 32'(valid), 32'h0);
        check("midreset_result", result, 32'h0);
        reset = 1'b1;
        vcount = 0;
        repeat (40) begin
            if (valid) vcount++;
            @(posedge clk); #1;
        end
        check("midreset_no_valid", 32'(vcount), 32'h0);

        // Back-to-back DIVU with start held into the first IDLE cycle
        start = 1'b1; op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd9;
        @(posedge clk); #1;
        rs1_data = 32'd77; rs2_data = 32'd5;
        nv = 0; pend = 1'b0;
        vt[0] = 0; vt[1] = 0; vr[0] = '0; vr[1] = '0;
        for (int c = 1; c <= 100; c++) begin
            if (pend) begin
                start = 1'b0;
                pend = 1'b0;
            end
            if (valid && nv < 2) begin
                vt[nv] = c;
                vr[nv] = result;
                nv++;
            end
            if (!busy && start && nv == 1) pend = 1'b1;
            if (nv == 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("b2b_count", 32'(nv), 32'd2);
        check("b2b_first_result", vr[0], 32'd111);
        check("b2b_second_result", vr[1], 32'd15);
        check("b2b_first_latency", 32'(vt[0]), 32'd33);
        check("b2b_spacing", 32'(vt[1] - vt[0]), 32'd34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
